// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file for the decode stage. It has two combinational read ports, a
// write-back port (ALU / MEM / LINK) and a late load-return port. A small
// in-order tag FIFO records the destinations of outstanding long-latency
// loads. A busy bit per register drives a combinational stall on RAW and WAW
// hazards.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   rs_addr / rs_data     read port A (combinational, write-first bypass)
//   rt_addr / rt_data     read port B (combinational, write-first bypass)
//   wb_en, wb_addr,       write-back request. wb_sel: 00 ALU, 01 MEM,
//   wb_sel, alu_result,   10 LINK (dest forced to LINK_REG, data link_pc),
//   mem_data, link_pc     11 reserved (no write)
//   ld_issue, ld_dest     issue a load whose data returns later into ld_dest
//   ld_rvalid, ld_rdata   data for the oldest outstanding load
//   stall                 front end must hold its current instruction
//   ld_full               tag FIFO holds MAX_LOADS entries
//   err_collide           sticky: wb and load return hit the same register
//
// Handshake: ld_issue is a request that takes effect only in a cycle where
// stall and ld_full are both low. wb_en commits only when stall is low. The
// requester must hold both requests while stall is high. ld_rvalid has no
// back-pressure. It always pops the oldest tag, and it is dropped when no
// load is outstanding.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LINK_REG  = 31,
  parameter int MAX_LOADS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_pc,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic              ld_rvalid,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic              stall,
  output logic              ld_full,
  output logic              err_collide
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = (MAX_LOADS > 1) ? $clog2(MAX_LOADS) : 1;
  localparam int CNT_W = $clog2(MAX_LOADS + 1);

  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LOADS);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_LOADS - 1);

  // State
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] tag_q [MAX_LOADS];
  logic [ADDR_W-1:0] tag_d [MAX_LOADS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_collide_q, err_collide_d;

  // Per-cycle decode
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_wdata;
  logic              fifo_empty;
  logic              ld_pop;
  logic [ADDR_W-1:0] ret_tag;
  logic              ld_wr;
  logic [DEPTH-1:0]  busy_eff;
  logic              wb_wr;
  logic              ld_accept;
  logic              collide;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Write-back destination and data select
  always_comb begin
    wb_dest = (wb_sel == SEL_LINK) ? LINK_IDX : wb_addr;
    case (wb_sel)
      SEL_MEM:  wb_wdata = mem_data;
      SEL_LINK: wb_wdata = link_pc;
      default:  wb_wdata = alu_result;
    endcase
  end

  // Load return: only meaningful when a tag is outstanding.
  assign fifo_empty = (count_q == '0);
  assign ld_full    = (count_q == CNT_MAX);
  assign ld_pop     = ld_rvalid & ~fifo_empty;
  assign ret_tag    = tag_q[rd_ptr_q];
  assign ld_wr      = ld_pop & (ret_tag != '0);

  // A register whose load is returning this cycle is already treated as free.
  // This removes the extra bubble between the return and the first use.
  always_comb begin
    busy_eff = busy_q;
    if (ld_pop) begin
      busy_eff[ret_tag] = 1'b0;
    end
  end

  assign stall = busy_eff[rs_addr]
               | busy_eff[rt_addr]
               | (wb_en & busy_eff[wb_dest])
               | (ld_issue & (ld_full | busy_eff[ld_dest]));

  // Writes to index 0 are squashed here, so r0 is never written or marked busy.
  assign wb_wr     = wb_en & (wb_sel != SEL_RSVD) & ~stall & (wb_dest != '0);
  assign ld_accept = ld_issue & ~stall & ~ld_full;
  assign collide   = wb_wr & ld_wr & (wb_dest == ret_tag);

  // Read port A: r0 is hard zero. Then the load return bypass, then the wb
  // bypass, then the array.
  always_comb begin
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (ld_wr && (ret_tag == rs_addr)) begin
      rs_data = ld_rdata;
    end else if (wb_wr && (wb_dest == rs_addr)) begin
      rs_data = wb_wdata;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (ld_wr && (ret_tag == rt_addr)) begin
      rt_data = ld_rdata;
    end else if (wb_wr && (wb_dest == rt_addr)) begin
      rt_data = wb_wdata;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

  // Next state
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_eff;
    tag_d         = tag_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_collide_d = err_collide_q | collide;

    // The load write comes second, so load data wins on a collision.
    if (wb_wr) begin
      regs_d[wb_dest] = wb_wdata;
    end
    if (ld_wr) begin
      regs_d[ret_tag] = ld_rdata;
    end

    // A load to r0 still takes a FIFO slot so returns stay in order. It never
    // sets a busy bit. If the head returns into the same register being
    // reissued, the new load's set must win over the clear.
    if (ld_accept) begin
      tag_d[wr_ptr_q] = ld_dest;
      wr_ptr_d        = next_ptr(wr_ptr_q);
      if (ld_dest != '0) begin
        busy_d[ld_dest] = 1'b1;
      end
    end
    if (ld_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({ld_accept, ld_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset clears everything, including outstanding tags. A late ld_rvalid
  // then finds the FIFO empty and is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < MAX_LOADS; i++) begin
        tag_q[i] <= '0;
      end
      busy_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_collide_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      tag_q         <= tag_d;
      busy_q        <= busy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_collide_q <= err_collide_d;
    end
  end

  assign err_collide = err_collide_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed scenarios followed by random traffic. A reference model tracks
// register contents as an array. It tracks pending loads as a queue of
// destination indices. A register counts as busy while its index remains in
// the queue after any same-cycle return is removed.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int LINK_REG  = 31;
  localparam int MAX_LOADS = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [ADDR_W-1:0] rs_addr, rt_addr, wb_addr, ld_dest;
  logic [DATA_W-1:0] rs_data, rt_data, alu_result, mem_data, link_pc, ld_rdata;
  logic              wb_en, ld_issue, ld_rvalid, stall, ld_full, err_collide;
  logic [1:0]        wb_sel;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .MAX_LOADS(MAX_LOADS)
  ) dut (
    .clock(clock), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .link_pc(link_pc),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .stall(stall), .ld_full(ld_full), .err_collide(err_collide)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mdl_regs [32];
  logic [ADDR_W-1:0] pend_q [$];
  logic              mdl_err;

  // Values the model derives for the current cycle's inputs
  bit                e_ret, e_full, e_stall, e_wb_go;
  logic [ADDR_W-1:0] e_head, e_wdst;
  logic [DATA_W-1:0] e_wdat;

  logic [DATA_W-1:0] exp_q [$];
  int cmp_cnt = 0;
  int err_cnt = 0;

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
    pend_q.delete();
    mdl_err = 1'b0;
  endfunction

  function automatic bit mdl_busy(input logic [ADDR_W-1:0] r);
    int n;
    n = 0;
    if (r == 0) return 1'b0;
    foreach (pend_q[i]) if (pend_q[i] == r) n++;
    if (e_ret && e_head == r) n--;
    return n > 0;
  endfunction

  function automatic void mdl_eval();
    e_ret  = ld_rvalid && (pend_q.size() != 0);
    e_head = (pend_q.size() != 0) ? pend_q[0] : '0;
    e_full = (pend_q.size() == MAX_LOADS);
    e_wdst = (wb_sel == 2'd2) ? ADDR_W'(LINK_REG) : wb_addr;
    e_wdat = (wb_sel == 2'd1) ? mem_data : (wb_sel == 2'd2) ? link_pc : alu_result;
    e_stall = mdl_busy(rs_addr) || mdl_busy(rt_addr) || (wb_en && mdl_busy(e_wdst))
           || (ld_issue && (e_full || mdl_busy(ld_dest)));
    e_wb_go = wb_en && (wb_sel != 2'd3) && !e_stall;
  endfunction

  function automatic logic [DATA_W-1:0] mdl_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (e_ret && e_head == a) return ld_rdata;
    if (e_wb_go && e_wdst == a) return e_wdat;
    return mdl_regs[a];
  endfunction

  function automatic void mdl_commit();
    mdl_eval();
    if (e_wb_go && e_wdst != 0) mdl_regs[e_wdst] = e_wdat;
    if (e_ret) begin
      if (e_head != 0) begin
        if (e_wb_go && e_wdst == e_head) mdl_err = 1'b1;
        mdl_regs[e_head] = ld_rdata;
      end
      void'(pend_q.pop_front());
    end
    if (ld_issue && !e_stall && !e_full) pend_q.push_back(ld_dest);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic settle();
    @(negedge clock);
    mdl_eval();
    exp_q.push_back(mdl_read(rs_addr));
    exp_q.push_back(mdl_read(rt_addr));
    exp_q.push_back(32'(e_stall));
    exp_q.push_back(32'(e_full));
    exp_q.push_back(32'(mdl_err));
    chk("rs_data",     rs_data,          exp_q.pop_front());
    chk("rt_data",     rt_data,          exp_q.pop_front());
    chk("stall",       32'(stall),       exp_q.pop_front());
    chk("ld_full",     32'(ld_full),     exp_q.pop_front());
    chk("err_collide", 32'(err_collide), exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) mdl_commit();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rs_addr = '0; rt_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_sel = 2'd0;
    alu_result = '0; mem_data = '0; link_pc = '0;
    ld_issue = 1'b0; ld_dest = '0; ld_rvalid = 1'b0; ld_rdata = '0;
  endtask

  task automatic wb(input logic [1:0] sel, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en = 1'b1; wb_sel = sel; wb_addr = a;
    alu_result = d; mem_data = d; link_pc = d;
  endtask

  // Reset is raised mid-cycle, away from any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    mdl_reset();
    settle();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    mdl_reset();
    #1;
    do_reset();

    // 1: reset state, then an ALU write bypassed and stored
    rs_addr = 5'd9; rt_addr = 5'd31;
    settle();
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_full", 32'(ld_full), 32'd0);
    chk("reset_rt31", rt_data, 32'd0);
    tick();
    idle(); wb(2'd0, 5'd5, 32'h1234); rs_addr = 5'd5;
    settle(); chk("t1_bypass", rs_data, 32'h1234); tick();
    idle(); rs_addr = 5'd5;
    settle(); chk("t1_array", rs_data, 32'h1234); tick();

    // 2: writes to r0 dropped; LINK forces r31
    idle(); wb(2'd0, 5'd0, 32'hFFFF_FFFF); rs_addr = 5'd0;
    settle(); chk("t2_r0_bypass", rs_data, 32'd0); tick();
    idle(); rs_addr = 5'd0;
    settle(); chk("t2_r0", rs_data, 32'd0); tick();
    idle(); wb(2'd2, 5'd3, 32'h0040_0008);
    settle(); tick();
    idle(); rs_addr = 5'd31; rt_addr = 5'd3;
    settle(); chk("t2_link", rs_data, 32'h0040_0008); chk("t2_link_nodest", rt_data, 32'd0); tick();

    // 3: load r8, RAW stall until the return cycle
    idle(); ld_issue = 1'b1; ld_dest = 5'd8;
    settle(); tick();
    idle(); rs_addr = 5'd8;
    settle(); chk("t3_stall_a", 32'(stall), 32'd1); tick();
    settle(); chk("t3_stall_b", 32'(stall), 32'd1); tick();
    ld_rvalid = 1'b1; ld_rdata = 32'hAA;
    settle(); chk("t3_ret_stall", 32'(stall), 32'd0); chk("t3_ret_data", rs_data, 32'hAA); tick();
    idle(); rs_addr = 5'd8;
    settle(); chk("t3_after", rs_data, 32'hAA); tick();

    // 4: fill the tag FIFO, third issue waits until a slot frees
    idle(); ld_issue = 1'b1; ld_dest = 5'd3;
    settle(); tick();
    ld_dest = 5'd4;
    settle(); tick();
    ld_dest = 5'd6;
    settle(); chk("t4_full", 32'(ld_full), 32'd1); chk("t4_stall", 32'(stall), 32'd1); tick();
    ld_rvalid = 1'b1; ld_rdata = 32'h33;
    settle(); chk("t4_stall_ret1", 32'(stall), 32'd1); tick();
    ld_rdata = 32'h44;
    settle(); chk("t4_accept", 32'(stall), 32'd0); tick();
    idle(); rs_addr = 5'd3; rt_addr = 5'd4;
    settle(); chk("t4_r3", rs_data, 32'h33); chk("t4_r4", rt_data, 32'h44); tick();
    idle(); ld_rvalid = 1'b1; ld_rdata = 32'h66;
    settle(); tick();

    // 5: wb and load return collide on r7
    idle(); ld_issue = 1'b1; ld_dest = 5'd7;
    settle(); tick();
    idle(); wb(2'd0, 5'd7, 32'h77); ld_rvalid = 1'b1; ld_rdata = 32'h7777; rs_addr = 5'd7;
    settle(); chk("t5_bypass", rs_data, 32'h7777); tick();
    idle(); rs_addr = 5'd7;
    settle(); chk("t5_r7", rs_data, 32'h7777); chk("t5_err", 32'(err_collide), 32'd1); tick();
    settle(); chk("t5_err_sticky", 32'(err_collide), 32'd1); tick();

    // 6: reset with two loads pending
    idle(); ld_issue = 1'b1; ld_dest = 5'd9;
    settle(); tick();
    ld_dest = 5'd10;
    settle(); tick();
    idle(); rs_addr = 5'd9; rt_addr = 5'd10;
    settle(); chk("t6_pre_stall", 32'(stall), 32'd1); tick();
    do_reset();
    settle(); chk("t6_stall", 32'(stall), 32'd0); chk("t6_err", 32'(err_collide), 32'd0); tick();
    ld_rvalid = 1'b1; ld_rdata = 32'hDEAD;
    settle(); tick();
    idle(); rs_addr = 5'd9; rt_addr = 5'd10;
    settle(); chk("t6_r9", rs_data, 32'd0); chk("t6_r10", rt_data, 32'd0); tick();

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        idle();
        do_reset();
      end
      rs_addr    = ADDR_W'($urandom_range(0, 11));
      rt_addr    = ADDR_W'($urandom_range(0, 11));
      wb_en      = ($urandom_range(0, 1) == 1);
      wb_sel     = 2'($urandom_range(0, 3));
      wb_addr    = ADDR_W'($urandom_range(0, 11));
      alu_result = $urandom;
      mem_data   = $urandom;
      link_pc    = $urandom;
      ld_issue   = ($urandom_range(0, 9) < 3);
      ld_dest    = ADDR_W'($urandom_range(0, 11));
      ld_rvalid  = ($urandom_range(0, 9) < 3);
      ld_rdata   = $urandom;
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
